// File: rtl/isp_blank_pkg.sv
// Shared encodings for the BLANK-stage highlight controller.
// Mode values, config register addresses and the frame FSM states.
package isp_blank_pkg;

    localparam logic [1:0] MODE_AUTO   = 2'd0;
    localparam logic [1:0] MODE_MANUAL = 2'd1;
    localparam logic [1:0] MODE_BYPASS = 2'd2;

    localparam logic [1:0] CFG_LO_TARGET  = 2'd0;
    localparam logic [1:0] CFG_HI_TARGET  = 2'd1;
    localparam logic [1:0] CFG_MANUAL_THR = 2'd2;
    localparam logic [1:0] CFG_MODE       = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_COUNT  = 2'd1,
        ST_EVAL   = 2'd2,
        ST_UPDATE = 2'd3
    } blank_state_e;

endpackage

// File: rtl/hl_pixel_counter.sv
// Counts href-qualified pixels with any component above the threshold; saturates.
// Latency: count reflects a pixel one clock after it is presented.
// Backpressure: none, the pixel stream is never stalled.
module hl_pixel_counter #(
    parameter int DATA_WIDTH = 8,
    parameter int CNT_WIDTH  = 22
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  clear,
    input  logic                  count_en,
    input  logic                  href,
    input  logic [DATA_WIDTH-1:0] red,
    input  logic [DATA_WIDTH-1:0] green,
    input  logic [DATA_WIDTH-1:0] blue,
    input  logic [DATA_WIDTH-1:0] threshold,
    output logic [CNT_WIDTH-1:0]  count
);

    logic hit;

    assign hit = (red > threshold) || (green > threshold) || (blue > threshold);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (count_en && href && hit && (count != '1)) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/highlight_threshold_ctrl.sv
// Per-frame highlight counter that adapts the suppressor threshold in the inter-frame gap.
// Latency: outputs update two clocks after the frame-end edge (E+2), with a one-cycle valid pulse.
// Backpressure: cfg_ready drops during EVAL/UPDATE; writes stall and land once back in IDLE.
module highlight_threshold_ctrl
    import isp_blank_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int CNT_WIDTH  = 22,
    parameter int THR_INIT   = 200,
    parameter int THR_MIN    = 160,
    parameter int THR_MAX    = 250,
    parameter int THR_STEP   = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  per_frame_vsync,
    input  logic                  per_frame_href,
    input  logic [DATA_WIDTH-1:0] per_img_red,
    input  logic [DATA_WIDTH-1:0] per_img_green,
    input  logic [DATA_WIDTH-1:0] per_img_blue,
    input  logic                  cfg_valid,
    output logic                  cfg_ready,
    input  logic [1:0]            cfg_addr,
    input  logic [CNT_WIDTH-1:0]  cfg_wdata,
    output logic [DATA_WIDTH-1:0] threshold,
    output logic                  filter_en,
    output logic [CNT_WIDTH-1:0]  hl_count,
    output logic                  hl_count_valid
);

    localparam int WIDE = (CNT_WIDTH > DATA_WIDTH) ? CNT_WIDTH : DATA_WIDTH;
    localparam logic [DATA_WIDTH:0] STEP_W   = (DATA_WIDTH+1)'(THR_STEP);
    localparam logic [DATA_WIDTH:0] MAX_W    = (DATA_WIDTH+1)'(THR_MAX);
    localparam logic [DATA_WIDTH:0] MIN_W    = (DATA_WIDTH+1)'(THR_MIN);
    localparam logic [DATA_WIDTH:0] MIN_PLUS = MIN_W + STEP_W;

    blank_state_e          state;
    logic                  vsync_d;
    logic                  seen_low;
    logic                  rise;
    logic                  fall;
    logic [CNT_WIDTH-1:0]  pix_count;
    logic [CNT_WIDTH-1:0]  frame_cnt;
    logic [DATA_WIDTH-1:0] thr_next;
    logic [DATA_WIDTH-1:0] thr_calc;
    logic [DATA_WIDTH:0]   thr_ext;
    logic [DATA_WIDTH:0]   thr_up;
    logic [DATA_WIDTH:0]   thr_dn;
    logic [CNT_WIDTH-1:0]  lo_target;
    logic [CNT_WIDTH-1:0]  hi_target;
    logic [DATA_WIDTH-1:0] manual_thr;
    logic [1:0]            mode;
    logic [WIDE-1:0]       wdata_ext;

    // A frame already in progress when reset releases would otherwise look like
    // a rise, so rise is only honoured once vsync has been observed low.
    assign rise = per_frame_vsync & ~vsync_d & seen_low;
    assign fall = ~per_frame_vsync & vsync_d;

    assign cfg_ready = (state == ST_IDLE) || (state == ST_COUNT);
    assign wdata_ext = WIDE'(cfg_wdata);

    hl_pixel_counter #(
        .DATA_WIDTH (DATA_WIDTH),
        .CNT_WIDTH  (CNT_WIDTH)
    ) u_counter (
        .clk       (clk),
        .rst_n     (rst_n),
        .clear     ((state == ST_IDLE) && rise),
        .count_en  (state == ST_COUNT),
        .href      (per_frame_href),
        .red       (per_img_red),
        .green     (per_img_green),
        .blue      (per_img_blue),
        .threshold (threshold),
        .count     (pix_count)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lo_target  <= '0;
            hi_target  <= '1;
            manual_thr <= DATA_WIDTH'(THR_INIT);
            mode       <= MODE_AUTO;
        end else if (cfg_valid && cfg_ready) begin
            case (cfg_addr)
                CFG_LO_TARGET:  lo_target  <= wdata_ext[CNT_WIDTH-1:0];
                CFG_HI_TARGET:  hi_target  <= wdata_ext[CNT_WIDTH-1:0];
                CFG_MANUAL_THR: manual_thr <= wdata_ext[DATA_WIDTH-1:0];
                default:        mode       <= wdata_ext[1:0];
            endcase
        end
    end

    // Widened arithmetic keeps step-up/step-down from wrapping before the clamp.
    always_comb begin
        thr_ext  = {1'b0, threshold};
        thr_up   = thr_ext + STEP_W;
        thr_dn   = thr_ext - STEP_W;
        thr_calc = threshold;
        case (mode)
            MODE_AUTO: begin
                if (frame_cnt > hi_target) begin
                    thr_calc = (thr_up > MAX_W) ? MAX_W[DATA_WIDTH-1:0] : thr_up[DATA_WIDTH-1:0];
                end else if (frame_cnt < lo_target) begin
                    thr_calc = (thr_ext < MIN_PLUS) ? MIN_W[DATA_WIDTH-1:0] : thr_dn[DATA_WIDTH-1:0];
                end
            end
            MODE_MANUAL: thr_calc = manual_thr;
            default:     thr_calc = threshold;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= ST_IDLE;
            vsync_d        <= 1'b0;
            seen_low       <= 1'b0;
            frame_cnt      <= '0;
            thr_next       <= DATA_WIDTH'(THR_INIT);
            threshold      <= DATA_WIDTH'(THR_INIT);
            filter_en      <= 1'b1;
            hl_count       <= '0;
            hl_count_valid <= 1'b0;
        end else begin
            vsync_d        <= per_frame_vsync;
            hl_count_valid <= 1'b0;
            if (!per_frame_vsync) begin
                seen_low <= 1'b1;
            end
            case (state)
                ST_IDLE: begin
                    if (rise) begin
                        state <= ST_COUNT;
                    end
                end
                ST_COUNT: begin
                    if (fall) begin
                        frame_cnt <= pix_count;
                        state     <= ST_EVAL;
                    end
                end
                ST_EVAL: begin
                    thr_next <= thr_calc;
                    state    <= ST_UPDATE;
                end
                ST_UPDATE: begin
                    threshold      <= thr_next;
                    filter_en      <= (mode < MODE_BYPASS);
                    hl_count       <= frame_cnt;
                    hl_count_valid <= 1'b1;
                    state          <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_highlight_threshold_ctrl.sv
// Directed frame vectors for highlight_threshold_ctrl; a second narrow instance
// (CNT_WIDTH = 4, THR_INIT = 249) covers counter saturation and the THR_MAX clamp.
module tb_highlight_threshold_ctrl;

    typedef struct {
        bit          use_b;
        bit          w0;
        logic [1:0]  a0;
        logic [21:0] d0;
        bit          w1;
        logic [1:0]  a1;
        logic [21:0] d1;
        int          wmode;   // second write: 0 before frame, 1 mid-frame, 2 held across EVAL/UPDATE
        int          n_hl;
        int          n_px;
        int          hl_val;
        int          lo_val;
        int          exp_cnt;
        int          exp_thr;
        bit          exp_fen;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        vsync = 1'b0;
    logic        href = 1'b0;
    logic        use_b = 1'b0;
    logic [7:0]  red = 8'd0, green = 8'd0, blue = 8'd0;
    logic        cfg_valid = 1'b0;
    logic [1:0]  cfg_addr = 2'd0;
    logic [21:0] cfg_wdata = 22'd0;

    logic        vs_a, vs_b, cv_a, cv_b;
    logic        ready_a, fen_a, val_a;
    logic [7:0]  thr_a;
    logic [21:0] cnt_a;
    logic        ready_b, fen_b, val_b;
    logic [7:0]  thr_b;
    logic [3:0]  cnt_b;

    logic        o_ready, o_fen, o_val;
    logic [7:0]  o_thr;
    logic [21:0] o_cnt;

    int n_checks = 0;
    int n_err = 0;
    int prev_thr, prev_cnt;
    bit prev_fen;
    vec_t vecs[15];

    assign vs_a = vsync & ~use_b;
    assign vs_b = vsync & use_b;
    assign cv_a = cfg_valid & ~use_b;
    assign cv_b = cfg_valid & use_b;

    assign o_ready = use_b ? ready_b : ready_a;
    assign o_fen   = use_b ? fen_b : fen_a;
    assign o_val   = use_b ? val_b : val_a;
    assign o_thr   = use_b ? thr_b : thr_a;
    assign o_cnt   = use_b ? {18'd0, cnt_b} : cnt_a;

    always #5 clk = ~clk;

    highlight_threshold_ctrl dut_a (
        .clk(clk), .rst_n(rst_n),
        .per_frame_vsync(vs_a), .per_frame_href(href),
        .per_img_red(red), .per_img_green(green), .per_img_blue(blue),
        .cfg_valid(cv_a), .cfg_ready(ready_a), .cfg_addr(cfg_addr), .cfg_wdata(cfg_wdata),
        .threshold(thr_a), .filter_en(fen_a), .hl_count(cnt_a), .hl_count_valid(val_a)
    );

    highlight_threshold_ctrl #(.CNT_WIDTH(4), .THR_INIT(249)) dut_b (
        .clk(clk), .rst_n(rst_n),
        .per_frame_vsync(vs_b), .per_frame_href(href),
        .per_img_red(red), .per_img_green(green), .per_img_blue(blue),
        .cfg_valid(cv_b), .cfg_ready(ready_b), .cfg_addr(cfg_addr), .cfg_wdata(cfg_wdata[3:0]),
        .threshold(thr_b), .filter_en(fen_b), .hl_count(cnt_b), .hl_count_valid(val_b)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic cfg_write(input logic [1:0] a, input logic [21:0] d);
        cfg_valid = 1'b1;
        cfg_addr  = a;
        cfg_wdata = d;
        tick();
        cfg_valid = 1'b0;
    endtask

    task automatic drive_pixel(input int i, input int n_hl, input int hl, input int lo);
        href  = 1'b1;
        red   = 8'(lo);
        green = 8'(lo);
        blue  = 8'(lo);
        if (i < n_hl) begin
            if (i % 3 == 0)      red   = 8'(hl);
            else if (i % 3 == 1) green = 8'(hl);
            else                 blue  = 8'(hl);
        end
    endtask

    function automatic vec_t mk(bit ub, bit w0, logic [1:0] a0, logic [21:0] d0,
                                bit w1, logic [1:0] a1, logic [21:0] d1, int wmode,
                                int n_hl, int n_px, int hl, int lo,
                                int ec, int et, bit ef);
        vec_t v;
        v.use_b = ub; v.w0 = w0; v.a0 = a0; v.d0 = d0;
        v.w1 = w1; v.a1 = a1; v.d1 = d1; v.wmode = wmode;
        v.n_hl = n_hl; v.n_px = n_px; v.hl_val = hl; v.lo_val = lo;
        v.exp_cnt = ec; v.exp_thr = et; v.exp_fen = ef;
        return v;
    endfunction

    task automatic run_frame(input vec_t v);
        use_b = v.use_b;
        if (v.w0) cfg_write(v.a0, v.d0);
        if (v.w1 && v.wmode == 0) cfg_write(v.a1, v.d1);
        vsync = 1'b1;
        tick();
        for (int i = 0; i < v.n_px; i++) begin
            drive_pixel(i, v.n_hl, v.hl_val, v.lo_val);
            if (v.w1 && v.wmode == 1 && i == v.n_px / 2) begin
                cfg_valid = 1'b1;
                cfg_addr  = v.a1;
                cfg_wdata = v.d1;
            end
            tick();
            cfg_valid = 1'b0;
        end
        href = 1'b0;
        tick();
        tick();
        vsync = 1'b0;
        tick();
        if (v.w1 && v.wmode == 2) begin
            cfg_valid = 1'b1;
            cfg_addr  = v.a1;
            cfg_wdata = v.d1;
        end
        check("cfg_ready at E", 32'(o_ready), 32'd0);
        check("valid at E", 32'(o_val), 32'd0);
        tick();
        check("cfg_ready at E+1", 32'(o_ready), 32'd0);
        check("valid at E+1", 32'(o_val), 32'd0);
        check("threshold held at E+1", 32'(o_thr), 32'(prev_thr));
        check("filter_en held at E+1", 32'(o_fen), 32'(prev_fen));
        check("hl_count held at E+1", o_cnt, 32'(prev_cnt));
        tick();
        check("valid at E+2", 32'(o_val), 32'd1);
        check("hl_count at E+2", o_cnt, 32'(v.exp_cnt));
        check("threshold at E+2", 32'(o_thr), 32'(v.exp_thr));
        check("filter_en at E+2", 32'(o_fen), 32'(v.exp_fen));
        check("cfg_ready at E+2", 32'(o_ready), 32'd1);
        tick();
        cfg_valid = 1'b0;
        check("valid at E+3", 32'(o_val), 32'd0);
        tick();
        tick();
        prev_thr = v.exp_thr;
        prev_cnt = v.exp_cnt;
        prev_fen = v.exp_fen;
    endtask

    initial begin
        int pulses;

        //          ub w0 a0 d0   w1 a1 d1  wm hl px  hv   lv   cnt thr fen
        vecs[0]  = mk(0, 0, 0, 0,   0, 0, 0,   0, 10, 16, 201, 200, 10, 200, 1);
        vecs[1]  = mk(0, 1, 1, 5,   0, 0, 0,   0, 10, 16, 255, 150, 10, 202, 1);
        vecs[2]  = mk(0, 0, 0, 0,   0, 0, 0,   0, 10, 16, 255, 150, 10, 204, 1);
        vecs[3]  = mk(0, 0, 0, 0,   0, 0, 0,   0, 10, 16, 255, 150, 10, 206, 1);
        vecs[4]  = mk(0, 1, 2, 162, 1, 3, 1,   0, 10, 16, 255, 150, 10, 162, 1);
        vecs[5]  = mk(0, 1, 3, 0,   1, 0, 100, 0, 0,  16, 255, 150, 0,  160, 1);
        vecs[6]  = mk(0, 0, 0, 0,   0, 0, 0,   0, 0,  16, 255, 150, 0,  160, 1);
        vecs[7]  = mk(0, 0, 0, 0,   1, 3, 2,   1, 10, 16, 255, 150, 10, 160, 0);
        vecs[8]  = mk(0, 1, 2, 180, 1, 3, 1,   0, 3,  16, 255, 150, 3,  180, 1);
        vecs[9]  = mk(0, 1, 3, 3,   0, 0, 0,   0, 3,  16, 255, 150, 3,  180, 0);
        vecs[10] = mk(0, 0, 0, 0,   1, 2, 190, 2, 4,  16, 255, 150, 4,  180, 0);
        vecs[11] = mk(0, 1, 3, 1,   0, 0, 0,   0, 2,  16, 255, 150, 2,  190, 1);
        vecs[12] = mk(0, 0, 0, 0,   0, 0, 0,   0, 7,  16, 255, 150, 7,  200, 1);
        vecs[13] = mk(1, 1, 1, 0,   0, 0, 0,   0, 20, 20, 255, 150, 15, 250, 1);
        vecs[14] = mk(1, 0, 0, 0,   0, 0, 0,   0, 20, 20, 255, 150, 15, 250, 1);

        #12;
        check("reset threshold", 32'(thr_a), 32'd200);
        check("reset filter_en", 32'(fen_a), 32'd1);
        check("reset hl_count", cnt_a, 32'd0);
        check("reset valid", 32'(val_a), 32'd0);
        check("reset cfg_ready", 32'(ready_a), 32'd1);
        check("reset threshold b", 32'(thr_b), 32'd249);
        rst_n = 1'b1;
        tick();
        tick();
        prev_thr = 200;
        prev_cnt = 0;
        prev_fen = 1'b1;

        for (int k = 0; k <= 11; k++) run_frame(vecs[k]);

        // Reset asserted in the middle of a frame; the tail of that frame must be ignored.
        use_b = 1'b0;
        vsync = 1'b1;
        tick();
        for (int i = 0; i < 5; i++) begin
            drive_pixel(i, 5, 255, 150);
            tick();
        end
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("async reset threshold", 32'(thr_a), 32'd200);
        check("async reset filter_en", 32'(fen_a), 32'd1);
        check("async reset hl_count", cnt_a, 32'd0);
        check("async reset valid", 32'(val_a), 32'd0);
        check("async reset cfg_ready", 32'(ready_a), 32'd1);
        #4 rst_n = 1'b1;
        @(posedge clk);
        #1;
        for (int i = 0; i < 5; i++) begin
            drive_pixel(i, 5, 255, 150);
            tick();
        end
        href = 1'b0;
        tick();
        vsync = 1'b0;
        pulses = 0;
        repeat (8) begin
            tick();
            if (val_a) pulses++;
        end
        check("no valid after partial frame", 32'(pulses), 32'd0);
        prev_thr = 200;
        prev_cnt = 0;
        prev_fen = 1'b1;
        run_frame(vecs[12]);

        prev_thr = 249;
        prev_cnt = 0;
        prev_fen = 1'b1;
        for (int k = 13; k <= 14; k++) run_frame(vecs[k]);

        $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_err);
        $finish;
    end

endmodule
